// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer width and depth legality.
package fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM, registered read, no reset.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk_in,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_level.sv
// Single-clock FIFO with level, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_level
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    localparam int PW       = ptr_width(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             write_in,
    input  logic [WIDTH-1:0] data_write_in,
    input  logic             read_in,
    output logic [WIDTH-1:0] data_read_out,
    output logic             rd_valid_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             almost_full_out,
    output logic             almost_empty_out,
    output logic [PW-1:0]    level_out,
    output logic             overflow_out,
    output logic             underflow_out,
    input  logic             err_clr_in
);

    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] AF_L    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_L    = PW'(AE_THRESH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_level: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW-1:0]    ram_cnt;
    logic [PW-1:0]    level;
    logic [PW-1:0]    level_nxt;
    logic             full_q;
    logic             af_q;
    logic             ae_q;
    logic             ovf_q;
    logic             unf_q;
    logic             fresh_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] ram_rdata;
    logic             wr_acc;
    logic             pop;
    logic             fetch;

    assign ram_cnt = wptr_q - rptr_q;
    assign wr_acc  = write_in && !full_q;

`ifdef FIFO_FWFT_EN
    // RAM words are fetched into the output stage as soon as it frees up.
    logic out_valid_q;

    assign pop   = read_in && out_valid_q;
    assign fetch = (ram_cnt != '0) && (!out_valid_q || pop);
    assign level = ram_cnt + PW'(out_valid_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid_q <= 1'b0;
        end else if (fetch) begin
            out_valid_q <= 1'b1;
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign empty_out    = !out_valid_q;
    assign rd_valid_out = out_valid_q;
`else
    logic empty_q;

    assign pop   = read_in && !empty_q;
    assign fetch = pop;
    assign level = ram_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            empty_q <= 1'b1;
        end else begin
            empty_q <= (level_nxt == '0);
        end
    end

    assign empty_out    = empty_q;
    assign rd_valid_out = fresh_q;
`endif

    assign level_nxt = level + PW'(wr_acc) - PW'(pop);

    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk_in (clk_in),
        .we     (wr_acc),
        .waddr  (wptr_q[AW-1:0]),
        .wdata  (data_write_in),
        .raddr  (rptr_q[AW-1:0]),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            fresh_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            wptr_q  <= wptr_q + PW'(wr_acc);
            rptr_q  <= rptr_q + PW'(fetch);
            full_q  <= (level_nxt == DEPTH_L);
            af_q    <= (level_nxt >= AF_L);
            ae_q    <= (level_nxt <= AE_L);
            fresh_q <= fetch;
            // RAM output changes every edge; keep the last fetched word
            if (fresh_q) begin
                hold_q <= ram_rdata;
            end
        end
    end

    // Error set wins over clear in the same cycle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (write_in && full_q) begin
                ovf_q <= 1'b1;
            end else if (err_clr_in) begin
                ovf_q <= 1'b0;
            end
            if (read_in && empty_out) begin
                unf_q <= 1'b1;
            end else if (err_clr_in) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign data_read_out    = fresh_q ? ram_rdata : hold_q;
    assign full_out         = full_q;
    assign almost_full_out  = af_q;
    assign almost_empty_out = ae_q;
    assign level_out        = level;
    assign overflow_out     = ovf_q;
    assign underflow_out    = unf_q;

endmodule

// File: tb/tb_fifo_sync_level.sv
// Randomized + directed bench for fifo_sync_level against a queue model.
// Honours FIFO_FWFT_EN to match the DUT build.
module tb_fifo_sync_level;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 2;
    localparam int PW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          write_in;
    logic [W-1:0]  data_write_in;
    logic          read_in;
    logic          err_clr_in;
    logic [W-1:0]  data_read_out;
    logic          rd_valid_out;
    logic          full_out;
    logic          empty_out;
    logic          almost_full_out;
    logic          almost_empty_out;
    logic [PW-1:0] level_out;
    logic          overflow_out;
    logic          underflow_out;

    always #5 clk_in = ~clk_in;

    fifo_sync_level #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .write_in         (write_in),
        .data_write_in    (data_write_in),
        .read_in          (read_in),
        .data_read_out    (data_read_out),
        .rd_valid_out     (rd_valid_out),
        .full_out         (full_out),
        .empty_out        (empty_out),
        .almost_full_out  (almost_full_out),
        .almost_empty_out (almost_empty_out),
        .level_out        (level_out),
        .overflow_out     (overflow_out),
        .underflow_out    (underflow_out),
        .err_clr_in       (err_clr_in)
    );

    typedef struct {
        logic [W-1:0] d;
        int           e;
    } ent_t;

    ent_t         q[$];
    bit           m_ovf;
    bit           m_unf;
    bit           m_rv;
    logic [W-1:0] m_dout;
    int           ecnt;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_valid();
`ifdef FIFO_FWFT_EN
        return (q.size() > 0) && (q[0].e < ecnt);
`else
        return m_rv;
`endif
    endfunction

    function automatic bit m_empty();
`ifdef FIFO_FWFT_EN
        return !m_valid();
`else
        return q.size() == 0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rv   = 1'b0;
        m_dout = '0;
    endtask

    task automatic check_all();
        check("level", level_out, q.size());
        check("full", full_out, q.size() == D);
        check("empty", empty_out, m_empty());
        check("almost_full", almost_full_out, q.size() >= AF);
        check("almost_empty", almost_empty_out, q.size() <= AE);
        check("overflow", overflow_out, m_ovf);
        check("underflow", underflow_out, m_unf);
        check("rd_valid", rd_valid_out, m_valid());
`ifdef FIFO_FWFT_EN
        if (m_valid()) check("data", data_read_out, q[0].d);
`else
        check("data", data_read_out, m_dout);
`endif
    endtask

    task automatic step(input bit w, input logic [W-1:0] d,
                        input bit r, input bit c);
        bit full;
        bit emp;
        bit racc;
        bit wacc;
        @(negedge clk_in);
        write_in      = w;
        data_write_in = d;
        read_in       = r;
        err_clr_in    = c;
        @(posedge clk_in);
        full = (q.size() == D);
        emp  = m_empty();
        ecnt++;
        racc = r && !emp;
        wacc = w && !full;
        m_ovf = (w && full) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = (r && emp) ? 1'b1 : (c ? 1'b0 : m_unf);
        if (racc) begin
            m_dout = q[0].d;
            void'(q.pop_front());
        end
        m_rv = racc;
        if (wacc) q.push_back('{d, ecnt});
        #1;
        check_all();
    endtask

    task automatic mid_reset();
        @(negedge clk_in);
        write_in   = 1'b0;
        read_in    = 1'b0;
        err_clr_in = 1'b0;
        #2 rst_in  = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_data", data_read_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in        = 1'b1;
        write_in      = 1'b0;
        read_in       = 1'b0;
        err_clr_in    = 1'b0;
        data_write_in = '0;
        ecnt          = 0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check_all();
        check("rst_data", data_read_out, 0);
        rst_in = 1'b0;

        // fill and drain in order
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // overflow from full, clear, readback
        for (int i = 0; i < 16; i++) step(1, 8'(i) ^ 8'h5a, 0, 0);
        step(0, 0, 0, 0);
        step(1, 8'hee, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // underflow, clear loses to set
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // steady level 8 with wrap
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 8'(8'h80 + i), 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // read+write at full: write rejected
        for (int i = 0; i < 16; i++) step(1, 8'(8'hc0 + i), 0, 0);
        step(0, 0, 0, 0);
        step(1, 8'hff, 1, 0);
        step(0, 0, 0, 1);

        // reset mid-burst at level 5
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0);
        mid_reset();
        step(1, 8'h99, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 1500; i++) begin
            int pw;
            pw = ((i / 150) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < pw, 8'($urandom),
                 $urandom_range(0, 99) < (100 - pw),
                 $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
